// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response port between the fetch unit and memory.
interface fetch_unit_if;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic        imem_ready;
    modport master (output imem_addr, imem_rd, input imem_data, imem_ready);
    modport slave  (input imem_addr, imem_rd, output imem_data, imem_ready);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC register and fetch FSM feeding decode; optional WAIT timeout under FETCH_TIMEOUT_EN.
module fetch_unit #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter logic [15:0] NOP_INSTR      = 16'h0800,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master imem,
    input  logic         redirect_en,
    input  logic [15:0]  redirect_pc,
    input  logic         halt_in,
    output logic [15:0]  instruction,
    output logic [15:0]  pc_plus2,
    output logic         inst_valid,
    output logic         halted,
    output logic         err
);
    typedef enum logic [1:0] {FETCH, WAIT, HALTED} state_t;
    state_t      state;
    logic [15:0] pc;
    logic        timeout;
    assign imem.imem_addr = pc;
    assign imem.imem_rd   = state != HALTED;
    assign halted         = state == HALTED;
`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    // counter holds completed WAIT cycles; the stalled cycle that reaches the limit halts
    assign timeout = state == WAIT && !halt_in && !redirect_en && !imem.imem_ready
                     && cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        cnt <= (rst || state != WAIT || halt_in || redirect_en || imem.imem_ready) ? '0 : cnt + CW'(1);
        err <= rst ? 1'b0 : err | timeout;
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instruction <= NOP_INSTR;
            pc_plus2    <= RESET_PC + 16'd2;
            inst_valid  <= 1'b0;
        end else if (state != HALTED) begin
            if (halt_in) begin
                state       <= HALTED;
                instruction <= NOP_INSTR;
                inst_valid  <= 1'b0;
            end else if (redirect_en) begin
                state       <= FETCH;
                pc          <= redirect_pc & 16'hFFFE;
                instruction <= NOP_INSTR;
                inst_valid  <= 1'b0;
            end else if (imem.imem_ready) begin
                state       <= FETCH;
                pc          <= pc + 16'd2;
                instruction <= imem.imem_data;
                pc_plus2    <= pc + 16'd2;
                inst_valid  <= 1'b1;
            end else begin
                state       <= timeout ? HALTED : WAIT;
                instruction <= NOP_INSTR;
                inst_valid  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, timeout sequence and randomized run against a reference model.
module tb_fetch_unit;
`ifdef FETCH_TIMEOUT_EN
    localparam int TO = 4;
    localparam bit TEN = 1'b1;
`else
    localparam int TO = 16;
    localparam bit TEN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst, halt_in, redirect_en;
    logic [15:0] redirect_pc, instruction, pc_plus2;
    logic        inst_valid, halted, err;
    int          checks = 0, errors = 0;
    fetch_unit_if bus ();
    fetch_unit #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .imem(bus), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .halt_in(halt_in), .instruction(instruction), .pc_plus2(pc_plus2),
        .inst_valid(inst_valid), .halted(halted), .err(err)
    );
    always #5 clk = ~clk;
    function automatic logic [15:0] d(input logic [15:0] a);
        return a ^ 16'hBEEF;
    endfunction
    assign bus.imem_data = d(bus.imem_addr);
    typedef struct {
        logic r, h, re; logic [15:0] rpc; logic rdy; logic chk;
        logic [15:0] addr; logic rd; logic [15:0] ins; logic v; logic [15:0] pp2; logic hl;
    } vec_t;
    vec_t tab[23];
    function automatic vec_t mk(input logic r, h, re, input logic [15:0] rpc, input logic rdy, chk,
                                input logic [15:0] addr, input logic rd, input logic [15:0] ins,
                                input logic v, input logic [15:0] pp2, input logic hl);
        vec_t t;
        t.r = r; t.h = h; t.re = re; t.rpc = rpc; t.rdy = rdy; t.chk = chk;
        t.addr = addr; t.rd = rd; t.ins = ins; t.v = v; t.pp2 = pp2; t.hl = hl;
        return t;
    endfunction
    function automatic logic [51:0] obs();
        return {bus.imem_addr, bus.imem_rd, instruction, inst_valid, pc_plus2, halted, err};
    endfunction
    task automatic chk(input string n, input logic [51:0] act, input logic [51:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got addr/rd/ins/v/pp2/hl/err=%h expected %h", n, act, exp);
        end
    endtask
    task automatic drive(input logic r, h, re, input logic [15:0] rpc, input logic rdy);
        rst = r; halt_in = h; redirect_en = re; redirect_pc = rpc; bus.imem_ready = rdy;
    endtask
    logic [15:0] m_pc, m_ins, m_pp2;
    logic        m_h, m_v, m_err;
    int          m_s;
    initial begin
        drive(1, 0, 0, 0, 0);
        tab[0]  = mk(1,0,0,16'h0000,0, 0, 16'h0000,1,16'h0800,0,16'h0002,0);
        tab[1]  = mk(1,0,0,16'h0000,0, 1, 16'h0000,1,16'h0800,0,16'h0002,0);
        tab[2]  = mk(0,0,0,16'h0000,1, 1, 16'h0000,1,16'h0800,0,16'h0002,0);
        tab[3]  = mk(0,0,0,16'h0000,1, 1, 16'h0002,1,d(16'h0000),1,16'h0002,0);
        tab[4]  = mk(0,0,0,16'h0000,0, 1, 16'h0004,1,d(16'h0002),1,16'h0004,0);
        tab[5]  = mk(0,0,0,16'h0000,0, 1, 16'h0004,1,16'h0800,0,16'h0004,0);
        tab[6]  = mk(0,0,0,16'h0000,0, 1, 16'h0004,1,16'h0800,0,16'h0004,0);
        tab[7]  = mk(0,0,0,16'h0000,1, 1, 16'h0004,1,16'h0800,0,16'h0004,0);
        tab[8]  = mk(0,0,1,16'h0041,1, 1, 16'h0006,1,d(16'h0004),1,16'h0006,0);
        tab[9]  = mk(0,0,0,16'h0000,1, 1, 16'h0040,1,16'h0800,0,16'h0006,0);
        tab[10] = mk(0,0,1,16'h0010,1, 1, 16'h0042,1,d(16'h0040),1,16'h0042,0);
        tab[11] = mk(0,1,1,16'h1234,1, 1, 16'h0010,1,16'h0800,0,16'h0042,0);
        for (int i = 12; i <= 16; i++)
            tab[i] = mk(0,0,1,16'h2000,1, 1, 16'h0010,0,16'h0800,0,16'h0042,1);
        tab[17] = mk(1,0,0,16'h0000,1, 1, 16'h0010,0,16'h0800,0,16'h0042,1);
        tab[18] = mk(0,0,0,16'h0000,0, 1, 16'h0000,1,16'h0800,0,16'h0002,0);
        tab[19] = mk(0,0,1,16'hFFFF,0, 1, 16'h0000,1,16'h0800,0,16'h0002,0);
        tab[20] = mk(0,0,0,16'h0000,1, 1, 16'hFFFE,1,16'h0800,0,16'h0002,0);
        tab[21] = mk(0,0,0,16'h0000,0, 1, 16'h0000,1,d(16'hFFFE),1,16'h0000,0);
        tab[22] = mk(0,0,0,16'h0000,0, 1, 16'h0000,1,16'h0800,0,16'h0000,0);
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(tab[i].r, tab[i].h, tab[i].re, tab[i].rpc, tab[i].rdy);
            #1;
            if (tab[i].chk)
                chk($sformatf("vec%0d", i), obs(),
                    {tab[i].addr, tab[i].rd, tab[i].ins, tab[i].v, tab[i].pp2, tab[i].hl, 1'b0});
        end
        // sustained stall: timeout halts after TO WAIT cycles, otherwise WAIT persists
        @(negedge clk); drive(1, 0, 0, 0, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0);
        for (int j = 1; j <= (TEN ? TO + 1 : 100); j++) begin
            @(negedge clk); #1;
            chk($sformatf("stall%0d", j), {bus.imem_addr, halted, err},
                {16'h0000, {2{TEN && j == TO + 1}}});
        end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            drive(i == 0 || $urandom_range(63) == 0, $urandom_range(39) == 0, $urandom_range(7) == 0,
                  16'($urandom), $urandom_range(3) != 0);
            #1;
            if (i > 0) chk($sformatf("rand%0d", i), obs(), {m_pc, ~m_h, m_ins, m_v, m_pp2, m_h, m_err});
            if (rst) begin
                m_pc = 16'h0000; m_ins = 16'h0800; m_pp2 = 16'h0002;
                m_h = 0; m_v = 0; m_err = 0; m_s = 0;
            end else if (!m_h) begin
                m_ins = 16'h0800; m_v = 0;
                if (halt_in) m_h = 1;
                else if (redirect_en) begin m_pc = {redirect_pc[15:1], 1'b0}; m_s = 0; end
                else if (bus.imem_ready) begin
                    m_ins = d(m_pc); m_v = 1; m_pc = m_pc + 16'd2; m_pp2 = m_pc; m_s = 0;
                end else begin
                    m_s++;
                    if (TEN && m_s == TO + 1) begin m_h = 1; m_err = 1; end
                end
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
